// File: rtl/csr_pkg.sv
// csr_pkg: shared definitions for the machine-mode CSR responder.
//   - CSR address map
//   - read/write response codes
//   - mstatus field positions and write masks
//   - write-channel FSM state type
//   - write-response classification helper
package csr_pkg;

    // CSR address map
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    // Response codes
    localparam logic [1:0] RRESP_OKAY   = 2'b00;
    localparam logic [1:0] RRESP_SLVERR = 2'b10;
    localparam logic [2:0] BRESP_OKAY   = 3'b000;
    localparam logic [2:0] BRESP_UNIMPL = 3'b010;
    localparam logic [2:0] BRESP_RO     = 3'b011;

    // mstatus fields; MPP is hardwired to M-mode
    localparam int          MSTATUS_MIE_BIT  = 3;
    localparam int          MSTATUS_MPIE_BIT = 7;
    localparam logic [31:0] MSTATUS_MPP_M    = 32'h0000_1800;

    // Writable bit masks
    localparam logic [31:0] MIE_WMASK   = 32'h0000_0888;
    localparam logic [31:0] MTVEC_WMASK = 32'hFFFF_FFFD;
    localparam logic [31:0] MEPC_WMASK  = 32'hFFFF_FFFC;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wstate_e;

    // Classifies a write address. Read-only space (addr[11:10]==11) and misa
    // take precedence over the unimplemented check.
    function automatic logic [2:0] csr_wr_resp(input logic [11:0] addr);
        logic [2:0] resp;
        if (addr[11:10] == 2'b11 || addr == CSR_MISA) begin
            resp = BRESP_RO;
        end else begin
            case (addr)
                CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
                CSR_MCAUSE, CSR_MTVAL, CSR_MCYCLE, CSR_MCYCLEH,
                CSR_MINSTRET, CSR_MINSTRETH: resp = BRESP_OKAY;
                default:                     resp = BRESP_UNIMPL;
            endcase
        end
        return resp;
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// csr_counter64: 64-bit wrapping counter with independently writable halves.
// Ports:
//   clk, reset  - clock, synchronous active-high reset (clears to 0)
//   inc_i       - increment request for this cycle
//   we_lo_i     - replace bits [31:0] with wdata_i (suppresses increment)
//   we_hi_i     - replace bits [63:32] with wdata_i (suppresses increment)
//   wdata_i     - write data for either half
//   value_o     - current counter value
module csr_counter64 (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc_i,
    input  logic        we_lo_i,
    input  logic        we_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] value_o
);

    logic [63:0] cnt_q, cnt_d;

    // A half-write leaves the other half untouched: no carry is propagated.
    always_comb begin
        cnt_d = cnt_q;
        if (we_lo_i) begin
            cnt_d[31:0] = wdata_i;
        end else if (we_hi_i) begin
            cnt_d[63:32] = wdata_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value_o = cnt_q;

endmodule

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR responder on the pipeline's CSR read/write bus.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   csrbus_ar*/r*       - read request (always accepted) and 1-cycle response
//   csrbus_w*/b*        - write request/accept and held write response
//   retire              - one pulse per committed instruction (minstret)
//   trap_*              - trap capture side-port from commit
module csr_file
    import csr_pkg::*;
#(
    parameter logic [31:0] HART_ID    = 32'd0,
    parameter logic [31:0] MISA_VALUE = 32'h4000_0100,
    parameter logic [31:0] MVENDORID  = 32'd0,
    parameter logic [31:0] MARCHID    = 32'd0,
    parameter logic [31:0] MIMPID     = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] csrbus_araddr,
    input  logic        csrbus_arvalid,
    output logic [31:0] csrbus_rdata,
    output logic [1:0]  csrbus_rresp,
    output logic        csrbus_rvalid,
    input  logic [11:0] csrbus_waddr,
    input  logic [31:0] csrbus_wdata,
    input  logic        csrbus_wvalid,
    output logic        csrbus_wready,
    output logic [2:0]  csrbus_bresp,
    output logic        csrbus_bvalid,
    input  logic        csrbus_bready,
    input  logic        retire,
    input  logic        trap_valid,
    input  logic [5:0]  trap_cause,
    input  logic [31:0] trap_val,
    input  logic [31:0] trap_pc
);

    wstate_e     state_q, state_d;
    logic [2:0]  bresp_q;
    logic        rvalid_q;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;

    logic        mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
    logic [31:0] mie_csr_q, mie_csr_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
    logic [31:0] mstatus_val;
    logic [63:0] mcycle, minstret;

    logic        wr_fire, wr_ok;
    logic [2:0]  wr_resp;

    assign wr_fire = csrbus_wvalid && csrbus_wready;
    assign wr_resp = csr_wr_resp(csrbus_waddr);
    assign wr_ok   = wr_fire && (wr_resp == BRESP_OKAY);

    always_comb begin
        mstatus_val                   = MSTATUS_MPP_M;
        mstatus_val[MSTATUS_MIE_BIT]  = mst_mie_q;
        mstatus_val[MSTATUS_MPIE_BIT] = mst_mpie_q;
    end

    // ---------------- write FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= W_IDLE;
            bresp_q <= BRESP_OKAY;
        end else begin
            state_q <= state_d;
            if (wr_fire) begin
                bresp_q <= wr_resp;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            W_IDLE:  if (csrbus_wvalid) state_d = W_RESP;
            W_RESP:  if (csrbus_bready) state_d = W_IDLE;
            default: state_d = W_IDLE;
        endcase
    end

    always_comb begin
        csrbus_wready = (state_q == W_IDLE);
        csrbus_bvalid = (state_q == W_RESP);
        csrbus_bresp  = bresp_q;
    end

    // ---------------- CSR state update ----------------
    // Trap capture is applied after the bus write so it overrides it.
    always_comb begin
        mst_mie_d  = mst_mie_q;
        mst_mpie_d = mst_mpie_q;
        mie_csr_d  = mie_csr_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        if (wr_ok) begin
            case (csrbus_waddr)
                CSR_MSTATUS: begin
                    mst_mie_d  = csrbus_wdata[MSTATUS_MIE_BIT];
                    mst_mpie_d = csrbus_wdata[MSTATUS_MPIE_BIT];
                end
                CSR_MIE:      mie_csr_d  = csrbus_wdata & MIE_WMASK;
                CSR_MTVEC:    mtvec_d    = csrbus_wdata & MTVEC_WMASK;
                CSR_MSCRATCH: mscratch_d = csrbus_wdata;
                CSR_MEPC:     mepc_d     = csrbus_wdata & MEPC_WMASK;
                CSR_MCAUSE:   mcause_d   = csrbus_wdata;
                CSR_MTVAL:    mtval_d    = csrbus_wdata;
                default: ;
            endcase
        end
        if (trap_valid) begin
            mepc_d     = trap_pc & MEPC_WMASK;
            mcause_d   = {trap_cause[5], 25'b0, trap_cause};
            mtval_d    = trap_val;
            mst_mpie_d = mst_mie_q;
            mst_mie_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mst_mie_q  <= 1'b0;
            mst_mpie_q <= 1'b0;
            mie_csr_q  <= '0;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else begin
            mst_mie_q  <= mst_mie_d;
            mst_mpie_q <= mst_mpie_d;
            mie_csr_q  <= mie_csr_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
        end
    end

    csr_counter64 u_mcycle (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (1'b1),
        .we_lo_i (wr_ok && csrbus_waddr == CSR_MCYCLE),
        .we_hi_i (wr_ok && csrbus_waddr == CSR_MCYCLEH),
        .wdata_i (csrbus_wdata),
        .value_o (mcycle)
    );

    csr_counter64 u_minstret (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (retire),
        .we_lo_i (wr_ok && csrbus_waddr == CSR_MINSTRET),
        .we_hi_i (wr_ok && csrbus_waddr == CSR_MINSTRETH),
        .wdata_i (csrbus_wdata),
        .value_o (minstret)
    );

    // ---------------- read path ----------------
    // Data is taken from the registered state, so a same-cycle write is not visible.
    always_comb begin
        rdata_d = '0;
        rresp_d = RRESP_OKAY;
        case (csrbus_araddr)
            CSR_MSTATUS:                 rdata_d = mstatus_val;
            CSR_MISA:                    rdata_d = MISA_VALUE;
            CSR_MIE:                     rdata_d = mie_csr_q;
            CSR_MTVEC:                   rdata_d = mtvec_q;
            CSR_MSCRATCH:                rdata_d = mscratch_q;
            CSR_MEPC:                    rdata_d = mepc_q;
            CSR_MCAUSE:                  rdata_d = mcause_q;
            CSR_MTVAL:                   rdata_d = mtval_q;
            CSR_MCYCLE, CSR_CYCLE:       rdata_d = mcycle[31:0];
            CSR_MCYCLEH, CSR_CYCLEH:     rdata_d = mcycle[63:32];
            CSR_MINSTRET, CSR_INSTRET:   rdata_d = minstret[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: rdata_d = minstret[63:32];
            CSR_MVENDORID:               rdata_d = MVENDORID;
            CSR_MARCHID:                 rdata_d = MARCHID;
            CSR_MIMPID:                  rdata_d = MIMPID;
            CSR_MHARTID:                 rdata_d = HART_ID;
            default:                     rresp_d = RRESP_SLVERR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RRESP_OKAY;
        end else begin
            rvalid_q <= csrbus_arvalid;
            if (csrbus_arvalid) begin
                rdata_q <= rdata_d;
                rresp_q <= rresp_d;
            end
        end
    end

    assign csrbus_rvalid = rvalid_q;
    assign csrbus_rdata  = rdata_q;
    assign csrbus_rresp  = rresp_q;

endmodule
